// File: rtl/bcd_seq_conv_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The calculator side is the master; the converter is the slave.
interface bcd_seq_conv_if #(
    parameter int DATA_W = 10
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              signed_en;
    logic              err_in;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              neg;
    logic              err_out;

    modport master (
        output start, data, signed_en, err_in,
        input  busy, done, bcd, neg, err_out
    );

    modport slave (
        input  start, data, signed_en, err_in,
        output busy, done, bcd, neg, err_out
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble converter: a 10-bit (optionally signed) value
// becomes four BCD digits plus sign, one shift per clock.
module bcd_seq_conv (
    input  logic           clk,
    input  logic           rst_n,
    bcd_seq_conv_if.slave  bus
);
    localparam int DATA_W = 10;
    localparam int DIG_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic                busy_r;
    logic                done_r;
    logic [DIG_W-1:0]    bcd_r;
    logic                neg_r;
    logic                err_r;
    logic [3:0]          cnt_r;
    logic [DIG_W-1:0]    digits_r;
    logic [DATA_W-1:0]   mag_r;
    logic                sign_r;

    logic [DIG_W-1:0]        digits_adj;
    logic [DIG_W+DATA_W-1:0] shift_nx;
    logic [DIG_W-1:0]        digits_nx;
    logic [DATA_W-1:0]       mag_nx;

    // Negation is done one bit wider so the most negative input maps to
    // its true magnitude (10'h200 -> 512) before narrowing back.
    function automatic logic [DATA_W-1:0] to_magnitude(
        input logic [DATA_W-1:0] d,
        input logic              s_en
    );
        logic signed [DATA_W:0] sx;
        sx = signed'({d[DATA_W-1], d});
        if (s_en && d[DATA_W-1])
            return DATA_W'(-sx);
        return d;
    endfunction

    function automatic logic is_negative(
        input logic [DATA_W-1:0] d,
        input logic              s_en
    );
        return s_en & d[DATA_W-1];
    endfunction

    function automatic logic [DIG_W-1:0] dabble_adjust(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] r;
        r = d;
        for (int i = 0; i < DIG_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign digits_adj = dabble_adjust(digits_r);
    assign shift_nx   = {digits_adj, mag_r} << 1;
    assign digits_nx  = shift_nx[DIG_W+DATA_W-1:DATA_W];
    assign mag_nx     = shift_nx[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bcd_r    <= '0;
            neg_r    <= 1'b0;
            err_r    <= 1'b0;
            cnt_r    <= '0;
            digits_r <= '0;
            mag_r    <= '0;
            sign_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.err_in) begin
                            // Error bypasses conversion and reports immediately.
                            state  <= DONE;
                            done_r <= 1'b1;
                            bcd_r  <= '0;
                            neg_r  <= 1'b0;
                            err_r  <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            mag_r    <= to_magnitude(bus.data, bus.signed_en);
                            sign_r   <= is_negative(bus.data, bus.signed_en);
                            cnt_r    <= '0;
                            digits_r <= '0;
                        end
                    end
                end
                SHIFT: begin
                    digits_r <= digits_nx;
                    mag_r    <= mag_nx;
                    cnt_r    <= cnt_r + 4'd1;
                    if (cnt_r == 4'(DATA_W - 1)) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        bcd_r  <= digits_nx;
                        neg_r  <= sign_r && (digits_nx != '0);
                        err_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd     = bcd_r;
    assign bus.neg     = neg_r;
    assign bus.err_out = err_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: expected results are queued when a
// request is driven and compared whenever done pulses.
module tb_bcd_seq_conv;
    logic clk;
    logic rst_n;

    bcd_seq_conv_if bus ();

    bcd_seq_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic        neg;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   idle_cnt  = 0;
    bit   cont_mode = 1'b0;
    bit   seen_first = 1'b0;

    function automatic logic [15:0] dec_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic exp_t model(input logic [9:0] d, input logic s, input logic e);
        exp_t x;
        int   v;
        if (e) begin
            x.bcd = 16'h0000;
            x.neg = 1'b0;
            x.err = 1'b1;
            return x;
        end
        v     = (s && d[9]) ? 1024 - int'(d) : int'(d);
        x.bcd = dec_bcd(v);
        x.neg = (s && d[9]) && (v != 0);
        x.err = 1'b0;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bcd", 32'(bus.bcd), 32'(e.bcd));
                chk("neg", 32'(bus.neg), 32'(e.neg));
                chk("err_out", 32'(bus.err_out), 32'(e.err));
            end
            if (cont_mode) begin
                if (seen_first)
                    chk("idle_gap", idle_cnt, 1);
                seen_first = 1'b1;
            end
            idle_cnt = 0;
        end else if (!bus.busy) begin
            idle_cnt++;
        end
    end

    // One request from IDLE; lat counts clock edges after the accepting
    // edge up to the one that raises done (error path raises it on the
    // accepting edge itself, so done is high in the very next cycle).
    task automatic conv(input logic [9:0] d, input logic s, input logic e);
        int lat;
        int busy_n;
        int d0;
        d0 = done_cnt;
        sb.push_back(model(d, s, e));
        bus.data      = d;
        bus.signed_en = s;
        bus.err_in    = e;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.data      = ~d;
        bus.signed_en = ~s;
        bus.err_in    = 1'b0;
        busy_n = int'(bus.busy);
        lat    = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            busy_n += int'(bus.busy);
        end
        chk("latency", lat, e ? 0 : 10);
        chk("busy_cycles", busy_n, e ? 1 : 11);
        @(posedge clk); #1;
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("done_after", 32'(bus.done), 32'd0);
        chk("one_done", done_cnt - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.data      = '0;
        bus.signed_en = 1'b0;
        bus.err_in    = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.bcd), 32'd0);
        chk("rst_neg", 32'(bus.neg), 32'd0);
        chk("rst_err", 32'(bus.err_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        conv(10'h3FF, 1'b0, 1'b0);
        conv(10'h200, 1'b1, 1'b0);
        conv(10'h3FF, 1'b1, 1'b0);
        conv(10'h1FF, 1'b1, 1'b0);
        conv(10'h07B, 1'b0, 1'b1);
        conv(10'd57,  1'b0, 1'b0);

        // Second start four cycles into a conversion must be dropped.
        d0 = done_cnt;
        sb.push_back(model(10'd987, 1'b0, 1'b0));
        bus.data = 10'd987; bus.signed_en = 1'b0; bus.err_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.data = 10'd321; bus.signed_en = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_start_dones", done_cnt - d0, 1);
        chk("ignored_start_sb", sb.size(), 0);

        // Reset five cycles after acceptance aborts without a done.
        d0 = done_cnt;
        sb.push_back(model(10'd456, 1'b0, 1'b0));
        bus.data = 10'd456; bus.signed_en = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_bcd", 32'(bus.bcd), 32'd0);
        chk("mid_rst_neg", 32'(bus.neg), 32'd0);
        chk("mid_rst_err", 32'(bus.err_out), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        conv(10'd0, 1'b1, 1'b0);

        // Continuous start across the whole unsigned range.
        cont_mode     = 1'b1;
        seen_first    = 1'b0;
        bus.signed_en = 1'b0;
        bus.err_in    = 1'b0;
        bus.start     = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w = 0;
            while (bus.busy && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            chk("cont_wait_idle", 32'(bus.busy), 32'd0);
            bus.data = 10'(i);
            sb.push_back(model(10'(i), 1'b0, 1'b0));
            @(posedge clk); #1;
            chk("cont_accept", 32'(bus.busy), 32'd1);
            if (i == 1023)
                bus.start = 1'b0;
        end
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        cont_mode = 1'b0;
        chk("cont_all_done", sb.size(), 0);
        chk("cont_final_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_seq_conv.md
BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: conversion request, sampled on the rising clk edge.
REQ-004 The block SHALL have the port data, input, 10 bits: the calculator answer to convert.
REQ-005 The block SHALL have the port signed_en, input, 1 bit: when 1, data is two's complement; when 0, data is unsigned.
REQ-006 The block SHALL have the port err_in, input, 1 bit: calculator error flag travelling with data.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while a request is in progress.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking new valid outputs.
REQ-009 The block SHALL have the port bcd, output, 16 bits: four BCD digits, with [15:12] as thousands and [3:0] as units.
REQ-010 The block SHALL have the port neg, output, 1 bit: the converted value was negative.
REQ-011 The block SHALL have the port err_out, output, 1 bit: registered copy of err_in for the converted value.

Function
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE, and busy SHALL be 1 exactly when the state is SHIFT or DONE.
REQ-013 start SHALL be accepted only on an edge where the state is IDLE; start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-014 On an accepting edge with err_in=0, the block SHALL latch the magnitude and sign, clear the shift counter and scratch digits, and enter SHIFT.
REQ-015 Magnitude and sign SHALL be computed as follows:
- signed_en=0: magnitude = data, sign = 0.
- signed_en=1 and data[9]=1: magnitude = two's-complement negation of data (11-bit internal, so 10'h200 gives 512), sign = 1.
- otherwise: magnitude = data, sign = 0.
REQ-016 Each SHIFT cycle SHALL do two steps:
- add 3 to every 4-bit scratch digit whose value is 5 or more;
- shift {digits, magnitude} left by one bit.
REQ-017 SHIFT SHALL last exactly 10 cycles; on the 10th shift edge the state SHALL go to DONE, and in the same edge bcd, neg and err_out (err_out=0) SHALL be loaded.
REQ-018 On an accepting edge with err_in=1, no shifting SHALL occur; the state SHALL go directly to DONE, loading bcd=16'h0000, neg=0 and err_out=1.
REQ-019 done SHALL be 1 only in the DONE state, which lasts exactly one cycle and is followed by IDLE.
REQ-020 Latency SHALL be: done high 10 cycles after the accepting edge for a normal conversion, and 1 cycle after it for the error path.
REQ-021 bcd, neg and err_out SHALL hold their values until the next load; they SHALL NOT change during SHIFT.
REQ-022 data, signed_en and err_in SHALL be sampled only on the accepting edge; changes to them afterwards SHALL have no effect.
REQ-023 Every 4-bit field of bcd SHALL be in the range 0..9 for all inputs, with a maximum output of 16'h1023 unsigned and 16'h0512 signed.
REQ-024 neg SHALL be 0 whenever the converted magnitude is 0.
REQ-025 start held high continuously SHALL produce back-to-back conversions: each acceptance occurs on the first IDLE edge after the previous DONE.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force the following, independent of clk:
- state to IDLE;
- busy=0, done=0;
- bcd=16'h0000, neg=0, err_out=0;
- shift counter and scratch registers to 0.
REQ-027 A reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start sampled after rst_n rises SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover unsigned full scale: signed_en=0, data=10'h3FF, start for 1 cycle -> busy for 11 cycles, done 10 cycles after acceptance, bcd=16'h1023, neg=0, err_out=0.
REQ-029 The bench SHALL cover the signed extremes:
- signed_en=1, data=10'h200 -> bcd=16'h0512, neg=1;
- signed_en=1, data=10'h3FF -> bcd=16'h0001, neg=1;
- signed_en=1, data=10'h1FF -> bcd=16'h0511, neg=0.
REQ-030 The bench SHALL cover the error path: err_in=1 with data=10'h07B at start -> done on the next cycle, bcd=16'h0000, err_out=1, busy high for exactly 1 cycle.
REQ-031 The bench SHALL cover start during a conversion: a second start pulse 4 cycles after acceptance with different data -> ignored, exactly one done, and outputs reflecting only the first data.
REQ-032 The bench SHALL cover reset mid-conversion: rst_n low 5 cycles after acceptance -> all outputs 0 immediately, no done; after release, data=10'd0 with signed_en=1 -> bcd=16'h0000, neg=0.
REQ-033 The bench SHALL cover continuous start with data stepped 0..1023 unsigned -> every result matches a decimal reference, and every done is separated by exactly one IDLE cycle.
